// File: rtl/acc_cmd_sequencer.sv
// Command front-end for the accumulator: buffers {op, data, attr} commands in a
// small FIFO and replays each one as the init / load / oe strobe sequence.
module acc_cmd_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int ATTR_WIDTH  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [DATA_WIDTH-1:0]       cmd_data,
  input  logic [ATTR_WIDTH-1:0]       cmd_attr,
  output logic                        signal_init,
  output logic                        signal_load,
  output logic                        signal_neg,
  output logic                        signal_oe,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [ATTR_WIDTH-1:0]       attr_in,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 2 + DATA_WIDTH + ATTR_WIDTH;
  localparam int CNT_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_OUT  = 2'd3;

  typedef enum logic [1:0] {IDLE, INIT, LOAD, OE} state_t;

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W:0]        level_reg;
  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  init_reg;
  logic                  load_reg;
  logic                  neg_reg;
  logic                  oe_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [ATTR_WIDTH-1:0] attr_reg;

  logic [ENTRY_W-1:0]    head;
  logic [1:0]            head_op;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ATTR_WIDTH-1:0] head_attr;
  logic                  push;
  logic                  pop;

  // Head is read combinationally so IDLE can pop and strobe on the same edge.
  assign head      = mem[rd_ptr_reg];
  assign head_op   = head[ENTRY_W-1 -: 2];
  assign head_data = head[ATTR_WIDTH +: DATA_WIDTH];
  assign head_attr = head[ATTR_WIDTH-1:0];

  assign cmd_ready = (level_reg != LEVEL_FULL);
  assign push      = cmd_valid && cmd_ready && !flush;
  assign pop       = (state_reg == IDLE) && (level_reg != '0) && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_op, cmd_data, cmd_attr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LEVEL_ONE;
        2'b01:   level_reg <= level_reg - LEVEL_ONE;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      init_reg  <= 1'b0;
      load_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      oe_reg    <= 1'b0;
      data_reg  <= '0;
      attr_reg  <= '0;
    end else if (flush) begin
      // Operand registers deliberately keep their value across a flush.
      state_reg <= IDLE;
      cnt_reg   <= '0;
      init_reg  <= 1'b0;
      load_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      oe_reg    <= 1'b0;
    end else begin
      init_reg <= 1'b0;
      oe_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            case (head_op)
              OP_INIT: begin
                state_reg <= INIT;
                init_reg  <= 1'b1;
              end
              OP_OUT: begin
                state_reg <= OE;
                oe_reg    <= 1'b1;
              end
              default: begin
                state_reg <= LOAD;
                load_reg  <= 1'b1;
                neg_reg   <= (head_op == OP_SUB);
                data_reg  <= head_data;
                attr_reg  <= head_attr;
                cnt_reg   <= '0;
              end
            endcase
          end
        end
        LOAD: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= IDLE;
            load_reg  <= 1'b0;
            neg_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign signal_init = init_reg;
  assign signal_load = load_reg;
  assign signal_neg  = neg_reg;
  assign signal_oe   = oe_reg;
  assign data_in     = data_reg;
  assign attr_in     = attr_reg;
  assign busy        = (level_reg != '0) || (state_reg != IDLE);
  assign fifo_level  = level_reg;

endmodule

// File: tb/tb_acc_cmd_sequencer.sv
// Bench for acc_cmd_sequencer: three builds (LOAD_CYCLES 2, 1, 3) share one
// stimulus stream and are compared every cycle against a command-queue model.
module tb_acc_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int OBS_W = 21;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic [3:0] attr;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic [3:0] cmd_attr = 4'd0;

  logic [2:0] s_init, s_load, s_neg, s_oe, s_busy, s_ready;
  logic [7:0] d_in [3];
  logic [3:0] a_in [3];
  logic [2:0] lvl  [3];
  logic [OBS_W-1:0] obs [3];

  int checks = 0;
  int errors = 0;

  // Model: per build, a FIFO of pending commands plus the command being
  // replayed and how many strobe cycles of it remain.
  cmd_t       mq [3][DEPTH];
  int         mcount [3];
  int         mleft  [3];
  cmd_t       mcur   [3];
  logic [7:0] mdata  [3];
  logic [3:0] mattr  [3];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      acc_cmd_sequencer #(
        .DATA_WIDTH (8),
        .ATTR_WIDTH (4),
        .FIFO_DEPTH (DEPTH),
        .LOAD_CYCLES(gi == 0 ? 2 : (gi == 1 ? 1 : 3))
      ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (s_ready[gi]),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_attr   (cmd_attr),
        .signal_init(s_init[gi]),
        .signal_load(s_load[gi]),
        .signal_neg (s_neg[gi]),
        .signal_oe  (s_oe[gi]),
        .data_in    (d_in[gi]),
        .attr_in    (a_in[gi]),
        .busy       (s_busy[gi]),
        .fifo_level (lvl[gi])
      );
      assign obs[gi] = {s_init[gi], s_load[gi], s_neg[gi], s_oe[gi], d_in[gi], a_in[gi],
                        s_busy[gi], s_ready[gi], lvl[gi]};
    end
  endgenerate

  function automatic int lc_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic model_tick();
    for (int k = 0; k < 3; k++) begin
      bit can_push;
      bit do_pop;
      can_push = cmd_valid && (mcount[k] < DEPTH) && rst_n && !flush;
      do_pop   = (mleft[k] == 0) && (mcount[k] > 0);
      if (!rst_n) begin
        mcount[k] = 0;
        mleft[k]  = 0;
        mcur[k]   = '0;
        mdata[k]  = 8'd0;
        mattr[k]  = 4'd0;
      end else if (flush) begin
        mcount[k] = 0;
        mleft[k]  = 0;
      end else begin
        if (mleft[k] > 0) begin
          mleft[k]--;
        end else if (do_pop) begin
          mcur[k] = mq[k][0];
          for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
          mcount[k]--;
          if (mcur[k].op == 2'd0 || mcur[k].op == 2'd3) begin
            mleft[k] = 1;
          end else begin
            mleft[k] = lc_of(k);
            mdata[k] = mcur[k].data;
            mattr[k] = mcur[k].attr;
          end
        end
        if (can_push) begin
          mq[k][mcount[k]] = {cmd_op, cmd_data, cmd_attr};
          mcount[k]++;
          if (k == 0)
            $display("push op=%0d data=%0d attr=%0d level=%0d", cmd_op, cmd_data, cmd_attr, mcount[k]);
        end
      end
    end
  endtask

  function automatic logic [OBS_W-1:0] expect_vec(int k);
    logic act;
    logic ld;
    logic [2:0] lv;
    act = (mleft[k] > 0);
    ld  = act && (mcur[k].op == 2'd1 || mcur[k].op == 2'd2);
    lv  = 3'(mcount[k]);
    return {act && (mcur[k].op == 2'd0), ld, ld && (mcur[k].op == 2'd2), act && (mcur[k].op == 2'd3),
            mdata[k], mattr[k], (mcount[k] > 0) || act, mcount[k] < DEPTH, lv};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] d, input logic fl);
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    cmd_attr  = 4'($urandom);
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    drive(0, 2'd0, 8'd0, 0);
    for (int c = 0; c < 40; c++) begin
      if (mcount[0] == 0 && mcount[1] == 0 && mcount[2] == 0 &&
          mleft[0] == 0 && mleft[1] == 0 && mleft[2] == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 2'd0, 8'd0, 0);
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expect_vec(k)) begin
        errors++;
        $display("FAIL reset_por dut%0d got %h expected %h", k, obs[k], expect_vec(k));
      end
    end
    rst_n = 1'b1;
    drive(1, 2'd1, 8'd55, 0);
    tick();
    drive(1, 2'd1, 8'd56, 0);
    tick();
    drive(0, 2'd0, 8'd0, 0);
    checks++;
    if (s_load[0] !== 1'b1 || d_in[0] !== 8'd55) begin
      errors++;
      $display("FAIL reset_setup load=%b data=%0d required load=1 data=55", s_load[0], d_in[0]);
    end
    #2;
    rst_n = 1'b0;
    model_tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== expect_vec(k)) begin
        errors++;
        $display("FAIL reset_async dut%0d got %h expected %h", k, obs[k], expect_vec(k));
      end
    end
    checks++;
    if (s_load[0] !== 1'b0 || d_in[0] !== 8'd0 || s_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_vals load=%b data=%0d ready=%b required 0 0 1", s_load[0], d_in[0], s_ready[0]);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_vec(k)) begin
          errors++;
          $display("FAIL reset_release dut%0d cyc%0d got %h expected %h", k, c, obs[k], expect_vec(k));
        end
      end
    end
  endtask

  task automatic test_basic();
    int         trace [14] = '{0, 1, 0, 2, 2, 0, 2, 2, 0, 3, 3, 0, 4, 0};
    logic [7:0] exp_d [14] = '{0, 0, 0, 4, 4, 4, 3, 3, 3, 5, 5, 5, 5, 5};
    logic [1:0] ops   [5]  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [7:0] dats  [5]  = '{8'd0, 8'd4, 8'd3, 8'd5, 8'd0};
    bit ok;
    for (int c = 0; c < 14; c++) begin
      if (c < 5) drive(1, ops[c], dats[c], 0);
      else       drive(0, 2'd0, 8'd0, 0);
      tick();
      begin
        int code;
        code = s_init[0] ? 1 : (s_load[0] && s_neg[0]) ? 3 : s_load[0] ? 2 : s_oe[0] ? 4 : 0;
        checks++;
        if (code != trace[c] || d_in[0] !== exp_d[c]) begin
          errors++;
          $display("FAIL basic_trace cyc%0d got strobe %0d data %0d required strobe %0d data %0d",
                   c, code, d_in[0], trace[c], exp_d[c]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_vec(k)) begin
          errors++;
          $display("FAIL basic_vec dut%0d cyc%0d got %h expected %h", k, c, obs[k], expect_vec(k));
        end
      end
    end
    drain(ok);
    checks++;
    if (!ok || s_busy !== 3'b000) begin
      errors++;
      $display("FAIL basic_drain busy=%b required 000", s_busy);
    end
  endtask

  task automatic test_full();
    for (int p = 0; p < 2; p++) begin
      logic [7:0] got [6];
      int  ngot = 0;
      int  idx = 0;
      bit  saw_full = 0;
      bit  done = 0;
      logic prev_load = 1'b0;
      for (int c = 0; c < 80; c++) begin
        bit acc;
        acc = (idx < 6) && (mcount[0] < DEPTH);
        if (idx < 6) drive(1, 2'd1, 8'(p * 10 + idx + 1), 0);
        else         drive(0, 2'd0, 8'd0, 0);
        tick();
        if (acc) idx++;
        if (s_load[0] && !prev_load && ngot < 6) begin
          got[ngot] = d_in[0];
          ngot++;
        end
        prev_load = s_load[0];
        if (s_ready[0] === 1'b0 && lvl[0] === 3'd4) saw_full = 1;
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs[k] !== expect_vec(k)) begin
            errors++;
            $display("FAIL full_vec pass%0d dut%0d cyc%0d got %h expected %h", p, k, c, obs[k], expect_vec(k));
          end
        end
        if (idx == 6 && mcount[0] == 0 && mcount[1] == 0 && mcount[2] == 0 &&
            mleft[0] == 0 && mleft[1] == 0 && mleft[2] == 0) begin
          done = 1;
          break;
        end
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL full_timeout pass%0d idx=%0d required 6", p, idx);
      end
      checks++;
      if (!saw_full) begin
        errors++;
        $display("FAIL full_ready pass%0d cmd_ready never low at level 4", p);
      end
      checks++;
      if (ngot != 6) begin
        errors++;
        $display("FAIL full_count pass%0d got %0d bursts required 6", p, ngot);
      end
      for (int i = 0; i < ngot; i++) begin
        checks++;
        if (got[i] !== 8'(p * 10 + i + 1)) begin
          errors++;
          $display("FAIL full_order pass%0d burst%0d got %0d required %0d", p, i, got[i], p * 10 + i + 1);
        end
      end
    end
  endtask

  task automatic test_simul();
    logic [7:0] got [4];
    int  ngot = 0;
    logic prev_load = 1'b0;
    bit  found = 0;
    bit  ok;
    for (int c = 0; c < 3; c++) begin
      drive(1, 2'd1, 8'(30 + c), 0);
      tick();
      if (s_load[0] && !prev_load && ngot < 4) begin got[ngot] = d_in[0]; ngot++; end
      prev_load = s_load[0];
    end
    drive(0, 2'd0, 8'd0, 0);
    for (int c = 0; c < 10; c++) begin
      if (mleft[0] == 0 && mcount[0] == 2) begin found = 1; break; end
      tick();
      if (s_load[0] && !prev_load && ngot < 4) begin got[ngot] = d_in[0]; ngot++; end
      prev_load = s_load[0];
    end
    checks++;
    if (!found || lvl[0] !== 3'd2) begin
      errors++;
      $display("FAIL simul_setup level=%0d required 2", lvl[0]);
    end
    drive(1, 2'd1, 8'd33, 0);
    tick();
    drive(0, 2'd0, 8'd0, 0);
    checks++;
    if (lvl[0] !== 3'd2 || s_load[0] !== 1'b1 || d_in[0] !== 8'd31) begin
      errors++;
      $display("FAIL simul_level level=%0d load=%b data=%0d required 2 1 31", lvl[0], s_load[0], d_in[0]);
    end
    if (s_load[0] && !prev_load && ngot < 4) begin got[ngot] = d_in[0]; ngot++; end
    prev_load = s_load[0];
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_load[0] && !prev_load && ngot < 4) begin got[ngot] = d_in[0]; ngot++; end
      prev_load = s_load[0];
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_vec(k)) begin
          errors++;
          $display("FAIL simul_vec dut%0d cyc%0d got %h expected %h", k, c, obs[k], expect_vec(k));
        end
      end
    end
    checks++;
    if (ngot != 4) begin
      errors++;
      $display("FAIL simul_count got %0d bursts required 4", ngot);
    end
    for (int i = 0; i < ngot; i++) begin
      checks++;
      if (got[i] !== 8'(30 + i)) begin
        errors++;
        $display("FAIL simul_order burst%0d got %0d required %0d", i, got[i], 30 + i);
      end
    end
    drain(ok);
    checks++;
    if (!ok || s_busy !== 3'b000) begin
      errors++;
      $display("FAIL simul_drain busy=%b required 000", s_busy);
    end
  endtask

  task automatic test_flush();
    logic [1:0] ops  [5] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [7:0] dats [5] = '{8'd0, 8'd7, 8'd40, 8'd41, 8'd42};
    bit ok;
    for (int c = 0; c < 5; c++) begin
      drive(1, ops[c], dats[c], 0);
      tick();
    end
    checks++;
    if (s_load[0] !== 1'b1 || d_in[0] !== 8'd7 || lvl[0] !== 3'd3) begin
      errors++;
      $display("FAIL flush_setup load=%b data=%0d level=%0d required 1 7 3", s_load[0], d_in[0], lvl[0]);
    end
    drive(1, 2'd1, 8'd99, 1);
    tick();
    drive(0, 2'd0, 8'd0, 0);
    checks++;
    if (s_load[0] !== 1'b0 || lvl[0] !== 3'd0 || s_busy[0] !== 1'b0 || d_in[0] !== 8'd7) begin
      errors++;
      $display("FAIL flush_effect load=%b level=%0d busy=%b data=%0d required 0 0 0 7",
               s_load[0], lvl[0], s_busy[0], d_in[0]);
    end
    for (int c = 0; c < 6; c++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_vec(k)) begin
          errors++;
          $display("FAIL flush_vec dut%0d cyc%0d got %h expected %h", k, c, obs[k], expect_vec(k));
        end
      end
      tick();
    end
    drain(ok);
    checks++;
    if (!ok || s_busy !== 3'b000 || d_in[0] !== 8'd7) begin
      errors++;
      $display("FAIL flush_after busy=%b data=%0d required 000 7", s_busy, d_in[0]);
    end
  endtask

  task automatic test_load_cycles();
    int nload [3] = '{0, 0, 0};
    int nneg  [3] = '{0, 0, 0};
    int nbad  [3] = '{0, 0, 0};
    bit ok;
    drive(1, 2'd2, 8'd9, 0);
    tick();
    drive(0, 2'd0, 8'd0, 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        if (s_load[k]) nload[k]++;
        if (s_neg[k])  nneg[k]++;
        if (s_load[k] && d_in[k] !== 8'd9) nbad[k]++;
        checks++;
        if (obs[k] !== expect_vec(k)) begin
          errors++;
          $display("FAIL lc_vec dut%0d cyc%0d got %h expected %h", k, c, obs[k], expect_vec(k));
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (nload[k] != lc_of(k) || nneg[k] != lc_of(k) || nbad[k] != 0) begin
        errors++;
        $display("FAIL lc_len dut%0d load=%0d neg=%0d baddata=%0d required %0d %0d 0",
                 k, nload[k], nneg[k], nbad[k], lc_of(k), lc_of(k));
      end
    end
    drain(ok);
    checks++;
    if (!ok || s_busy !== 3'b000) begin
      errors++;
      $display("FAIL lc_drain busy=%b required 000", s_busy);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int c = 0; c < 120; c++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), ($urandom_range(0, 19) == 0));
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== expect_vec(k)) begin
          errors++;
          $display("FAIL random_vec dut%0d cyc%0d got %h expected %h", k, c, obs[k], expect_vec(k));
        end
      end
    end
    drain(ok);
    checks++;
    if (!ok || s_busy !== 3'b000) begin
      errors++;
      $display("FAIL random_drain busy=%b required 000", s_busy);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mcount[k] = 0;
      mleft[k]  = 0;
      mcur[k]   = '0;
      mdata[k]  = 8'd0;
      mattr[k]  = 4'd0;
    end
    test_reset();
    test_basic();
    test_full();
    test_simul();
    test_flush();
    test_load_cycles();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
